// File: rtl/kvs_req_arbiter.sv
`timescale 1ns/1ps
// kvs_req_arbiter
// Shares the single db_top lookup port between the two Ethernet parsers
// (ETH0, ETH1). Requests are granted round-robin and issued to db_top one
// cycle after acceptance. The id of each requester is remembered in an
// in-order tag FIFO so that every db_top result is returned to the port
// that asked for it. A flush request stops issuing and reports when all
// outstanding lookups have drained.
//
// Ports
//   clk, rst_n                 db_clk, asynchronous active-low reset
//   req0_* / req1_*            per-port key/flag/valid in, ready out
//   db_key/db_flag/db_valid    lookup issue towards db_top
//   db_rsp_valid/db_rsp_flag   in-order results from db_top
//   rsp0_* / rsp1_*            per-port result pulse and flag
//   flush / flush_done         drain request (level) and drained status
//   outst_cnt                  lookups currently in flight
//   rsp_err                    sticky: result arrived with nothing in flight
module kvs_req_arbiter #(
   parameter int KEY_SIZE  = 96,
   parameter int FLAG_W    = 4,
   parameter int MAX_OUTST = 8,
   parameter int OUTST_AW  = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [KEY_SIZE-1:0] req0_key,
   input  logic [FLAG_W-1:0]   req0_flag,
   input  logic                req0_valid,
   output logic                req0_ready,
   input  logic [KEY_SIZE-1:0] req1_key,
   input  logic [FLAG_W-1:0]   req1_flag,
   input  logic                req1_valid,
   output logic                req1_ready,
   output logic [KEY_SIZE-1:0] db_key,
   output logic [FLAG_W-1:0]   db_flag,
   output logic                db_valid,
   input  logic                db_rsp_valid,
   input  logic [FLAG_W-1:0]   db_rsp_flag,
   output logic                rsp0_valid,
   output logic [FLAG_W-1:0]   rsp0_flag,
   output logic                rsp1_valid,
   output logic [FLAG_W-1:0]   rsp1_flag,
   input  logic                flush,
   output logic                flush_done,
   output logic [OUTST_AW:0]   outst_cnt,
   output logic                rsp_err
);

   localparam logic [OUTST_AW:0] FULL_CNT = MAX_OUTST[OUTST_AW:0];

   typedef enum logic [1:0] {
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_t;

   state_t                r_state;
   state_t                w_nextState;
   logic                  r_rrPtr;
   logic                  r_tagFifo [MAX_OUTST];
   logic [OUTST_AW-1:0]   r_wrPtr;
   logic [OUTST_AW-1:0]   r_rdPtr;
   logic [OUTST_AW:0]     r_outstCnt;
   logic                  r_dbValid;
   logic [KEY_SIZE-1:0]   r_dbKey;
   logic [FLAG_W-1:0]     r_dbFlag;
   logic                  r_rsp0Valid;
   logic                  r_rsp1Valid;
   logic [FLAG_W-1:0]     r_rsp0Flag;
   logic [FLAG_W-1:0]     r_rsp1Flag;
   logic                  r_rspErr;

   logic                  w_canIssue;
   logic                  w_grant0;
   logic                  w_grant1;
   logic                  w_accept;
   logic                  w_pop;
   logic                  w_popTag;

   // Arbitration. Ready is held low during reset so that every output reads
   // zero while rst_n is asserted. Fullness is judged on the registered count
   // only, so a pop in the same cycle never frees a slot early. When both
   // ports are valid the round-robin pointer picks the winner.
   assign w_canIssue = rst_n && (r_state == ST_RUN) && (r_outstCnt != FULL_CNT);
   assign w_grant0   = w_canIssue && req0_valid && (!req1_valid || !r_rrPtr);
   assign w_grant1   = w_canIssue && req1_valid && (!req0_valid ||  r_rrPtr);
   assign w_accept   = w_grant0 || w_grant1;
   assign w_pop      = db_rsp_valid && (r_outstCnt != '0);
   assign w_popTag   = r_tagFifo[r_rdPtr];

   assign req0_ready = w_grant0;
   assign req1_ready = w_grant1;
   assign db_key     = r_dbKey;
   assign db_flag    = r_dbFlag;
   assign db_valid   = r_dbValid;
   assign rsp0_valid = r_rsp0Valid;
   assign rsp0_flag  = r_rsp0Flag;
   assign rsp1_valid = r_rsp1Valid;
   assign rsp1_flag  = r_rsp1Flag;
   assign flush_done = (r_state == ST_DONE);
   assign outst_cnt  = r_outstCnt;
   assign rsp_err    = r_rspErr;

   // Tag storage carries no reset: only entries between the read and write
   // pointers are meaningful, and the pointers themselves are reset.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_tagFifo[r_wrPtr] <= w_grant1;
      end
   end

   // Tag FIFO pointers, in-flight counter and round-robin pointer. The
   // pointers wrap naturally at MAX_OUTST because of their width. A push and
   // a pop in the same cycle leave the count unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wrPtr    <= '0;
         r_rdPtr    <= '0;
         r_outstCnt <= '0;
         r_rrPtr    <= 1'b0;
      end else begin
         if (w_accept) begin
            r_wrPtr <= r_wrPtr + 1'b1;
            r_rrPtr <= w_grant0;
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         case ({w_accept, w_pop})
            2'b10:   r_outstCnt <= r_outstCnt + 1'b1;
            2'b01:   r_outstCnt <= r_outstCnt - 1'b1;
            default: r_outstCnt <= r_outstCnt;
         endcase
      end
   end

   // Issue stage towards db_top: a single-cycle valid pulse one cycle after
   // acceptance; key and flag keep their last value between lookups.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dbValid <= 1'b0;
         r_dbKey   <= '0;
         r_dbFlag  <= '0;
      end else begin
         r_dbValid <= w_accept;
         if (w_accept) begin
            r_dbKey  <= w_grant1 ? req1_key  : req0_key;
            r_dbFlag <= w_grant1 ? req1_flag : req0_flag;
         end
      end
   end

   // Response routing: the FIFO head names the port that owns the result.
   // A result with nothing in flight is dropped and flagged, sticky until
   // reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp0Valid <= 1'b0;
         r_rsp1Valid <= 1'b0;
         r_rsp0Flag  <= '0;
         r_rsp1Flag  <= '0;
         r_rspErr    <= 1'b0;
      end else begin
         r_rsp0Valid <= w_pop && !w_popTag;
         r_rsp1Valid <= w_pop &&  w_popTag;
         if (w_pop && !w_popTag) begin
            r_rsp0Flag <= db_rsp_flag;
         end
         if (w_pop && w_popTag) begin
            r_rsp1Flag <= db_rsp_flag;
         end
         if (db_rsp_valid && (r_outstCnt == '0)) begin
            r_rspErr <= 1'b1;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_nextState;
      end
   end

   // FSM next state. Draining completes only once nothing is counted in
   // flight and the issue stage is not still presenting a lookup to db_top.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_RUN: begin
            if (flush) w_nextState = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!flush) begin
               w_nextState = ST_RUN;
            end else if ((r_outstCnt == '0) && !r_dbValid) begin
               w_nextState = ST_DONE;
            end
         end
         ST_DONE: begin
            if (!flush) w_nextState = ST_RUN;
         end
         default: w_nextState = ST_RUN;
      endcase
   end

endmodule

// File: tb/tb_kvs_req_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for kvs_req_arbiter. A queue-based reference model
// tracks which port owns each lookup in flight and predicts every output
// each cycle; directed scenarios add hand-computed literal expectations.
module tb_kvs_req_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [95:0] req0_key = '0;
   logic [3:0]  req0_flag = '0;
   logic        req0_valid = 1'b0;
   logic        req0_ready;
   logic [95:0] req1_key = '0;
   logic [3:0]  req1_flag = '0;
   logic        req1_valid = 1'b0;
   logic        req1_ready;
   logic [95:0] db_key;
   logic [3:0]  db_flag;
   logic        db_valid;
   logic        db_rsp_valid = 1'b0;
   logic [3:0]  db_rsp_flag = '0;
   logic        rsp0_valid;
   logic [3:0]  rsp0_flag;
   logic        rsp1_valid;
   logic [3:0]  rsp1_flag;
   logic        flush = 1'b0;
   logic        flush_done;
   logic [3:0]  outst_cnt;
   logic        rsp_err;

   int passCount = 0;
   int totalChecks = 0;

   kvs_req_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .req0_key(req0_key), .req0_flag(req0_flag), .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req1_key(req1_key), .req1_flag(req1_flag), .req1_valid(req1_valid), .req1_ready(req1_ready),
      .db_key(db_key), .db_flag(db_flag), .db_valid(db_valid),
      .db_rsp_valid(db_rsp_valid), .db_rsp_flag(db_rsp_flag),
      .rsp0_valid(rsp0_valid), .rsp0_flag(rsp0_flag),
      .rsp1_valid(rsp1_valid), .rsp1_flag(rsp1_flag),
      .flush(flush), .flush_done(flush_done),
      .outst_cnt(outst_cnt), .rsp_err(rsp_err)
   );

   // 10 ns clock.
   always #5 clk = ~clk;

   // Single comparison point; every check in the bench goes through here.
   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      totalChecks++;
      if (act !== exp) begin
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end else begin
         passCount++;
      end
   endtask

   // Reference model state: lookups in flight are a queue of owner ids.
   int          mState = 0;
   int          tagQ[$];
   int          mRr = 0;
   logic        mDbValid = 1'b0;
   logic [95:0] mDbKey = '0;
   logic [3:0]  mDbFlag = '0;
   logic        mR0V = 1'b0;
   logic        mR1V = 1'b0;
   logic [3:0]  mR0F = '0;
   logic [3:0]  mR1F = '0;
   logic        mErr = 1'b0;
   int          seen0 = 0;
   int          seen1 = 0;

   // Compare process: at each falling edge the inputs for the coming rising
   // edge are stable, so the model checks the present outputs and then
   // advances itself across that edge.
   initial begin
      int g;
      int nState;
      int tag;
      bit canIssue;
      forever begin
         @(negedge clk);
         if (rsp0_valid === 1'b1) seen0++;
         if (rsp1_valid === 1'b1) seen1++;
         if (!rst_n) begin
            mState = 0; tagQ.delete(); mRr = 0;
            mDbValid = 0; mDbKey = '0; mDbFlag = '0;
            mR0V = 0; mR1V = 0; mR0F = '0; mR1F = '0; mErr = 0;
         end
         canIssue = rst_n && (mState == 0) && (tagQ.size() != 8);
         g = -1;
         if (canIssue) begin
            if (req0_valid && req1_valid) g = mRr;
            else if (req0_valid)          g = 0;
            else if (req1_valid)          g = 1;
         end
         checkOutput("model.req0_ready", 128'(req0_ready), 128'(g == 0));
         checkOutput("model.req1_ready", 128'(req1_ready), 128'(g == 1));
         checkOutput("model.db_valid",   128'(db_valid),   128'(mDbValid));
         checkOutput("model.db_key",     128'(db_key),     128'(mDbKey));
         checkOutput("model.db_flag",    128'(db_flag),    128'(mDbFlag));
         checkOutput("model.rsp0_valid", 128'(rsp0_valid), 128'(mR0V));
         checkOutput("model.rsp0_flag",  128'(rsp0_flag),  128'(mR0F));
         checkOutput("model.rsp1_valid", 128'(rsp1_valid), 128'(mR1V));
         checkOutput("model.rsp1_flag",  128'(rsp1_flag),  128'(mR1F));
         checkOutput("model.outst_cnt",  128'(outst_cnt),  128'(tagQ.size()));
         checkOutput("model.rsp_err",    128'(rsp_err),    128'(mErr));
         checkOutput("model.flush_done", 128'(flush_done), 128'(mState == 2));
         if (rst_n) begin
            nState = mState;
            case (mState)
               0: if (flush) nState = 1;
               1: begin
                  if (!flush) nState = 0;
                  else if (tagQ.size() == 0 && !mDbValid) nState = 2;
               end
               default: if (!flush) nState = 0;
            endcase
            mR0V = 0;
            mR1V = 0;
            if (db_rsp_valid) begin
               if (tagQ.size() > 0) begin
                  tag = tagQ.pop_front();
                  if (tag == 0) begin mR0V = 1; mR0F = db_rsp_flag; end
                  else          begin mR1V = 1; mR1F = db_rsp_flag; end
               end else begin
                  mErr = 1;
               end
            end
            mDbValid = (g >= 0);
            if (g == 0) begin mDbKey = req0_key; mDbFlag = req0_flag; end
            if (g == 1) begin mDbKey = req1_key; mDbFlag = req1_flag; end
            if (g >= 0) begin
               tagQ.push_back(g);
               mRr = (g == 0) ? 1 : 0;
            end
            mState = nState;
         end
      end
   end

   // Optional automatic db_top responder: answers each issued lookup
   // immediately with an incrementing flag.
   bit       respEn = 0;
   int       pend = 0;
   logic [3:0] rflag = 4'h5;

   // Advance one clock; inputs change 2 ns after the rising edge.
   task automatic nextCycle();
      @(posedge clk);
      #2;
      if (db_valid === 1'b1) pend++;
      if (respEn && pend > 0) begin
         db_rsp_valid = 1'b1;
         db_rsp_flag  = rflag;
         rflag        = rflag + 4'h1;
         pend--;
      end else begin
         db_rsp_valid = 1'b0;
      end
   endtask

   // Hold one port valid until it has been accepted n times (bounded).
   logic [95:0] keyCtr = 96'h100;
   task automatic applyStimulus(input int port, input int n);
      int got = 0;
      for (int i = 0; i < 40 && got < n; i++) begin
         if (port == 0) begin req0_valid = 1; req0_key = keyCtr; req0_flag = keyCtr[3:0]; end
         else           begin req1_valid = 1; req1_key = keyCtr; req1_flag = keyCtr[3:0]; end
         #1;
         if ((port == 0 && req0_ready) || (port == 1 && req1_ready)) begin
            got++;
            keyCtr = keyCtr + 96'h11;
         end
         nextCycle();
      end
      req0_valid = 0;
      req1_valid = 0;
      checkOutput("accepts_issued", 128'(got), 128'(n));
   endtask

   // Watchdog so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int grants[6];
      int n;
      int acc;

      repeat (2) nextCycle();
      #1;
      checkOutput("reset.db_valid", 128'(db_valid), 128'(0));
      checkOutput("reset.outst_cnt", 128'(outst_cnt), 128'(0));
      rst_n = 1;

      // 1: ETH0 only
      nextCycle();
      req0_valid = 1; req0_key = 96'hA; req0_flag = 4'h1;
      #1;
      checkOutput("t1.ready0", 128'(req0_ready), 128'(1));
      checkOutput("t1.ready1", 128'(req1_ready), 128'(0));
      nextCycle();
      req0_valid = 0;
      #1;
      checkOutput("t1.db_valid", 128'(db_valid), 128'(1));
      checkOutput("t1.db_key", 128'(db_key), 128'(96'hA));
      checkOutput("t1.db_flag", 128'(db_flag), 128'(1));
      db_rsp_valid = 1; db_rsp_flag = 4'h3;
      nextCycle();
      #1;
      checkOutput("t1.rsp0_valid", 128'(rsp0_valid), 128'(1));
      checkOutput("t1.rsp0_flag", 128'(rsp0_flag), 128'(3));
      checkOutput("t1.rsp1_valid", 128'(rsp1_valid), 128'(0));
      nextCycle();
      #1;
      checkOutput("t1.rsp0_pulse_end", 128'(rsp0_valid), 128'(0));

      // 2: both valid, round-robin with responder running (fresh reset so ETH0 leads)
      rst_n = 0;
      nextCycle();
      rst_n = 1;
      pend = 0; respEn = 1; seen0 = 0; seen1 = 0;
      req0_valid = 1; req0_key = 96'hB0; req0_flag = 4'h2;
      req1_valid = 1; req1_key = 96'hB1; req1_flag = 4'h7;
      n = 0;
      for (int i = 0; i < 30 && n < 6; i++) begin
         #1;
         if (req0_ready) begin grants[n] = 0; n++; end
         else if (req1_ready) begin grants[n] = 1; n++; end
         nextCycle();
      end
      req0_valid = 0; req1_valid = 0;
      checkOutput("t2.accepts", 128'(n), 128'(6));
      for (int i = 0; i < 6; i++) checkOutput("t2.grant_order", 128'(grants[i]), 128'(i % 2));
      repeat (8) nextCycle();
      checkOutput("t2.rsp0_count", 128'(seen0), 128'(3));
      checkOutput("t2.rsp1_count", 128'(seen1), 128'(3));
      respEn = 0;
      nextCycle();

      // 3: no responses, saturate outstanding limit
      req0_valid = 1; req0_key = 96'hC0; req0_flag = 4'h4;
      acc = 0;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (req0_ready) acc++;
         nextCycle();
      end
      #1;
      checkOutput("t3.accepts", 128'(acc), 128'(8));
      checkOutput("t3.cnt_full", 128'(outst_cnt), 128'(8));
      db_rsp_valid = 1; db_rsp_flag = 4'hE;
      #1;
      checkOutput("t3.full_blocks_on_pop", 128'(req0_ready), 128'(0));
      nextCycle();
      #1;
      checkOutput("t3.cnt_after_pop", 128'(outst_cnt), 128'(7));
      checkOutput("t3.ready_after_pop", 128'(req0_ready), 128'(1));
      nextCycle();
      #1;
      checkOutput("t3.cnt_refull", 128'(outst_cnt), 128'(8));
      checkOutput("t3.ready_refull", 128'(req0_ready), 128'(0));
      req0_valid = 0;
      for (int k = 0; k < 4; k++) begin
         db_rsp_valid = 1; db_rsp_flag = 4'h8;
         nextCycle();
      end
      #1;
      checkOutput("t4.cnt_before", 128'(outst_cnt), 128'(4));

      // 4: accept and pop together at cnt=4
      req1_valid = 1; req1_key = 96'hD1; req1_flag = 4'hD;
      db_rsp_valid = 1; db_rsp_flag = 4'h9;
      #1;
      checkOutput("t4.ready1", 128'(req1_ready), 128'(1));
      nextCycle();
      req1_valid = 0;
      #1;
      checkOutput("t4.cnt_same", 128'(outst_cnt), 128'(4));
      checkOutput("t4.rsp0_flag", 128'(rsp0_flag), 128'(9));
      for (int k = 0; k < 4; k++) begin
         db_rsp_valid = 1; db_rsp_flag = 4'(k);
         nextCycle();
         #1;
         checkOutput("t4.route0", 128'(rsp0_valid), 128'(k < 3));
         checkOutput("t4.route1", 128'(rsp1_valid), 128'(k == 3));
      end
      checkOutput("t4.last_flag1", 128'(rsp1_flag), 128'(3));
      nextCycle();

      // 5: flush with 3 in flight
      applyStimulus(1, 3);
      flush = 1;
      nextCycle();
      req0_valid = 1;
      #1;
      checkOutput("t5.drain_ready0", 128'(req0_ready), 128'(0));
      checkOutput("t5.drain_not_done", 128'(flush_done), 128'(0));
      checkOutput("t5.drain_cnt", 128'(outst_cnt), 128'(3));
      for (int k = 0; k < 3; k++) begin
         db_rsp_valid = 1; db_rsp_flag = 4'hA;
         nextCycle();
      end
      for (int i = 0; i < 10 && flush_done !== 1'b1; i++) begin
         nextCycle();
         #1;
      end
      checkOutput("t5.flush_done", 128'(flush_done), 128'(1));
      checkOutput("t5.done_ready0", 128'(req0_ready), 128'(0));
      flush = 0;
      nextCycle();
      #1;
      checkOutput("t5.run_again_done", 128'(flush_done), 128'(0));
      checkOutput("t5.run_again_ready", 128'(req0_ready), 128'(1));
      nextCycle();
      req0_valid = 0;
      db_rsp_valid = 1; db_rsp_flag = 4'h6;
      nextCycle();
      nextCycle();
      #1;
      checkOutput("t5.cnt_zero", 128'(outst_cnt), 128'(0));

      // 6: asynchronous reset with 5 in flight
      applyStimulus(0, 5);
      req0_valid = 1;
      #1;
      rst_n = 0;
      #1;
      checkOutput("t6.async_db_valid", 128'(db_valid), 128'(0));
      checkOutput("t6.async_cnt", 128'(outst_cnt), 128'(0));
      checkOutput("t6.async_ready0", 128'(req0_ready), 128'(0));
      checkOutput("t6.async_db_key", 128'(db_key), 128'(0));
      req0_valid = 0;
      nextCycle();
      rst_n = 1;
      nextCycle();
      #1;
      checkOutput("t6.err_clear", 128'(rsp_err), 128'(0));
      db_rsp_valid = 1; db_rsp_flag = 4'hF;
      nextCycle();
      #1;
      checkOutput("t6.rsp_err", 128'(rsp_err), 128'(1));
      checkOutput("t6.no_rsp0", 128'(rsp0_valid), 128'(0));
      checkOutput("t6.no_rsp1", 128'(rsp1_valid), 128'(0));
      checkOutput("t6.cnt_stays", 128'(outst_cnt), 128'(0));
      repeat (2) nextCycle();

      $display("%0d/%0d checks passed", passCount, totalChecks);
      $finish;
   end

endmodule
